// File: rtl/boid_pkg.sv
// Shared types and constants for the boid update accelerator controller.
package boid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ITR   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int WB_CYCLES = 7;
    localparam int READ_LAT  = 1;
    localparam int WB_CNT_W  = 3;

    // Thermometer code with bits [k:0] set.
    function automatic logic [WB_CYCLES-1:0] therm(input logic [WB_CNT_W-1:0] k);
        logic [WB_CYCLES-1:0] t;
        t = '0;
        for (int b = 0; b < WB_CYCLES; b++) begin
            t[b] = (k >= WB_CNT_W'(b));
        end
        return t;
    endfunction

endpackage

// File: rtl/xcel_wb_shift.sv
// Write-back sequencer: thermometer enables across the write-back window
// and a flag marking its final cycle.
module xcel_wb_shift
    import boid_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    output logic [WB_CYCLES-1:0] wb_en,
    output logic                 last
);

    logic [WB_CNT_W-1:0] k_q;

    // Counter sits at zero whenever the window is closed, so each window starts at k=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q <= '0;
        end else if (en && !last) begin
            k_q <= k_q + 1'b1;
        end else begin
            k_q <= '0;
        end
    end

    assign last  = en && (k_q == WB_CNT_W'(WB_CYCLES - 1));
    assign wb_en = en ? therm(k_q) : '0;

endmodule

// File: rtl/boid_xcel_ctrl.sv
// Frame controller for the boid accelerator: per target boid it loads the
// target, streams every neighbour through the datapath, then writes back.
module boid_xcel_ctrl
    import boid_pkg::*;
#(
    parameter int N_BOIDS = 32,
    parameter int ADDR_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [31:0]          wr_x,
    output logic [31:0]          wr_y,
    output logic [31:0]          wr_vx,
    output logic [31:0]          wr_vy,
    input  logic [31:0]          x_out_xcel,
    input  logic [31:0]          y_out_xcel,
    input  logic [31:0]          vx_out_xcel,
    input  logic [31:0]          vy_out_xcel,
    output logic                 r_en_tot,
    output logic                 r_en_itr,
    output logic [WB_CYCLES-1:0] wb_en,
    output logic [2:0]           state_dbg
);

    // start/busy/done: start is sampled only in IDLE (one cycle is enough);
    // busy stays high from the cycle after acceptance through the last
    // write-back, and done pulses for one cycle with busy low.

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BOIDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, j_q, rd_hold_q;
    logic              wb_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q       <= '0;
            j_q       <= '0;
            rd_hold_q <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                i_q <= '0;
            end else if (wb_last && i_q != LAST_IDX) begin
                i_q <= i_q + 1'b1;
            end
            if (state_q == ST_LOAD) begin
                j_q <= '0;
            end else if (state_q == ST_ITR) begin
                j_q <= j_q + 1'b1;
            end
            rd_hold_q <= rd_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_ITR;
            ST_ITR:   if (j_q == LAST_IDX) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_WB;
            ST_WB:    if (wb_last) state_d = (i_q == LAST_IDX) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Data arriving in an ITR cycle belongs to the address issued one cycle earlier (j-1).
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rd_addr  = rd_hold_q;
        wr_en    = 1'b0;
        wr_addr  = '0;
        r_en_tot = 1'b0;
        r_en_itr = 1'b0;
        case (state_q)
            ST_LOAD: begin
                busy    = 1'b1;
                rd_addr = i_q;
            end
            ST_ITR: begin
                busy     = 1'b1;
                rd_addr  = j_q;
                r_en_tot = (j_q == '0);
                r_en_itr = (j_q != '0) && ((j_q - ADDR_W'(1)) != i_q);
            end
            ST_DRAIN: begin
                busy     = 1'b1;
                r_en_itr = (LAST_IDX != i_q);
            end
            ST_WB: begin
                busy    = 1'b1;
                wr_en   = wb_last;
                wr_addr = wb_last ? i_q : '0;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    xcel_wb_shift u_wb_shift (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == ST_WB),
        .wb_en (wb_en),
        .last  (wb_last)
    );

    assign wr_x      = x_out_xcel;
    assign wr_y      = y_out_xcel;
    assign wr_vx     = vx_out_xcel;
    assign wr_vy     = vy_out_xcel;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_boid_xcel_ctrl.sv
// Directed bench for boid_xcel_ctrl with a 4-boid memory and a toy datapath.
module tb_boid_xcel_ctrl;

    localparam int N        = 4;
    localparam int AW       = 8;
    localparam int PER_BOID = N + 9;
    localparam int FRAME    = N * PER_BOID;
    localparam logic [31:0] X_STEP = 32'h0140_0000;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy, done, wr_en, r_en_tot, r_en_itr;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [31:0]   wr_x, wr_y, wr_vx, wr_vy;
    logic [31:0]   x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel;
    logic [6:0]    wb_en;
    logic [2:0]    state_dbg;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    boid_xcel_ctrl #(.N_BOIDS(N), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_addr     (rd_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_vx       (wr_vx),
        .wr_vy       (wr_vy),
        .x_out_xcel  (x_out_xcel),
        .y_out_xcel  (y_out_xcel),
        .vx_out_xcel (vx_out_xcel),
        .vy_out_xcel (vy_out_xcel),
        .r_en_tot    (r_en_tot),
        .r_en_itr    (r_en_itr),
        .wb_en       (wb_en),
        .state_dbg   (state_dbg)
    );

    // boid memory (1-cycle read latency) and toy datapath
    logic [31:0] mem_x [N];
    logic [31:0] mem_y [N];
    logic [31:0] mem_vx[N];
    logic [31:0] mem_vy[N];
    logic [31:0] rd_x = '0, rd_y = '0, rd_vx = '0, rd_vy = '0;
    logic [31:0] tgt_x = '0, tgt_y = '0, tgt_vx = '0, tgt_vy = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] base_x[N];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int n = 0; n < N; n++) begin
                mem_x[n]  <= 32'h10 * n;
                mem_y[n]  <= 32'h200 + n;
                mem_vx[n] <= 32'h3000 + n;
                mem_vy[n] <= 32'h4000 + n;
            end
            mem_ready <= 1'b1;
        end else begin
            rd_x  <= mem_x[int'(rd_addr) % N];
            rd_y  <= mem_y[int'(rd_addr) % N];
            rd_vx <= mem_vx[int'(rd_addr) % N];
            rd_vy <= mem_vy[int'(rd_addr) % N];
            if (wr_en) begin
                mem_x[int'(wr_addr) % N]  <= wr_x;
                mem_y[int'(wr_addr) % N]  <= wr_y;
                mem_vx[int'(wr_addr) % N] <= wr_vx;
                mem_vy[int'(wr_addr) % N] <= wr_vy;
            end
            if (r_en_tot) begin
                tgt_x  <= rd_x;
                tgt_y  <= rd_y;
                tgt_vx <= rd_vx;
                tgt_vy <= rd_vy;
            end
        end
    end

    assign x_out_xcel  = tgt_x + X_STEP;
    assign y_out_xcel  = tgt_y ^ 32'h0000_FFFF;
    assign vx_out_xcel = tgt_vx + 32'd1;
    assign vy_out_xcel = tgt_vy - 32'd1;

    task automatic test_reset();
        logic [18:0] act;
        reset = 1'b0;
        start = 1'b1;
        repeat (4) @(negedge clk);
        act = {busy, done, r_en_tot, r_en_itr, wr_en, wb_en, state_dbg, 3'b000};
        chk_cnt++;
        if (act !== 19'd0) $display("FAIL reset_ctrl got %b exp 0", act);
        else pass_cnt++;
        chk_cnt++;
        if (rd_addr !== '0) $display("FAIL reset_rd_addr got %0h exp 0", rd_addr);
        else pass_cnt++;
        chk_cnt++;
        if (wr_addr !== '0) $display("FAIL reset_wr_addr got %0h exp 0", wr_addr);
        else pass_cnt++;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({busy, state_dbg} !== 4'b0) $display("FAIL reset_start_ignored got busy=%b state=%0d exp 0/0", busy, state_dbg);
        else pass_cnt++;
    endtask

    task automatic run_frame(input int extra_start);
        int t, off, k, nb, itr_t2;
        logic [11:0]   exp_v, act_v;
        logic [AW-1:0] exp_rd;
        logic          chk_rd;
        logic [31:0]   exp_nx;
        itr_t2 = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < N; n++) base_x[n] = mem_x[n];
        @(negedge clk);
        for (int c = 1; c <= FRAME + 1; c++) begin
            start  = (c == extra_start);
            exp_v  = '0;
            chk_rd = 1'b0;
            exp_rd = '0;
            nb     = 0;
            t      = (c - 1) / PER_BOID;
            off    = (c - 1) % PER_BOID;
            if (c == FRAME + 1) begin
                exp_v[10] = 1'b1;
            end else begin
                exp_v[11] = 1'b1;
                if (off == 0) begin
                    chk_rd = 1'b1; exp_rd = AW'(t);
                end else if (off <= N) begin
                    chk_rd = 1'b1; exp_rd = AW'(off - 1);
                    exp_v[9] = (off == 1);
                    exp_v[8] = (off >= 2) && (off - 2 != t);
                    nb = off - 2;
                end else if (off == N + 1) begin
                    chk_rd = 1'b1; exp_rd = AW'(N - 1);
                    exp_v[8] = (N - 1 != t);
                    nb = N - 1;
                end else begin
                    k = off - N - 2;
                    exp_v[6:0] = 7'((1 << (k + 1)) - 1);
                    exp_v[7] = (k == 6);
                end
            end
            act_v = {busy, done, r_en_tot, r_en_itr, wr_en, wb_en};
            chk_cnt++;
            if (act_v !== exp_v) $display("FAIL frame_ctrl c=%0d got %b exp %b", c, act_v, exp_v);
            else pass_cnt++;
            if (chk_rd) begin
                chk_cnt++;
                if (rd_addr !== exp_rd) $display("FAIL frame_rd_addr c=%0d got %0d exp %0d", c, rd_addr, exp_rd);
                else pass_cnt++;
            end
            if (exp_v[9]) begin
                chk_cnt++;
                if (rd_x !== base_x[t]) $display("FAIL target_data c=%0d got %h exp %h", c, rd_x, base_x[t]);
                else pass_cnt++;
            end
            if (exp_v[8]) begin
                if (t == 2) itr_t2++;
                exp_nx = (nb < t) ? base_x[nb] + X_STEP : base_x[nb];
                chk_cnt++;
                if (rd_x !== exp_nx) $display("FAIL neighbour_data c=%0d nb=%0d got %h exp %h", c, nb, rd_x, exp_nx);
                else pass_cnt++;
            end
            if (exp_v[7]) begin
                chk_cnt++;
                if (wr_addr !== AW'(t)) $display("FAIL wr_addr c=%0d got %0d exp %0d", c, wr_addr, t);
                else pass_cnt++;
                chk_cnt++;
                if (wr_x !== base_x[t] + X_STEP) $display("FAIL wr_x c=%0d got %h exp %h", c, wr_x, base_x[t] + X_STEP);
                else pass_cnt++;
                chk_cnt++;
                if ({wr_x, wr_y, wr_vx, wr_vy} !== {x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel})
                    $display("FAIL wr_passthru c=%0d got %h %h %h %h exp %h %h %h %h", c, wr_x, wr_y, wr_vx, wr_vy,
                             x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel);
                else pass_cnt++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk_cnt++;
        if (itr_t2 != 3) $display("FAIL itr_count_t2 got %0d exp 3", itr_t2);
        else pass_cnt++;
        chk_cnt++;
        if ({busy, done, state_dbg} !== 5'b0) $display("FAIL frame_idle_after got busy=%b done=%b state=%0d exp 0", busy, done, state_dbg);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int wr_seen;
        logic [31:0] snap2, snap3;
        wr_seen = 0;
        @(negedge clk);
        start = 1'b1;
        snap2 = mem_x[2];
        snap3 = mem_x[3];
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 30; c++) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_cnt++;
        if ({busy, done, r_en_tot, r_en_itr, wr_en, wb_en, state_dbg} !== 15'd0)
            $display("FAIL abort_ctrl got %b exp 0", {busy, done, r_en_tot, r_en_itr, wr_en, wb_en, state_dbg});
        else pass_cnt++;
        chk_cnt++;
        if ({rd_addr, wr_addr} !== '0) $display("FAIL abort_addr got %h exp 0", {rd_addr, wr_addr});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
        end
        chk_cnt++;
        if (wr_seen != 0 || busy !== 1'b0) $display("FAIL abort_no_write got writes=%0d busy=%b exp 0/0", wr_seen, busy);
        else pass_cnt++;
        chk_cnt++;
        if ({mem_x[2], mem_x[3]} !== {snap2, snap3})
            $display("FAIL abort_mem got %h %h exp %h %h", mem_x[2], mem_x[3], snap2, snap3);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        test_reset();
        run_frame(0);
        run_frame(20);
        test_abort();
        run_frame(0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
